imem_loader: RTL and testbench

Byte-serial program loader that fills the instruction memory before the core runs. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to consecutive instruction-memory word addresses. The core is held in reset until the whole image is loaded and verified; it is then released.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Byte-serial program loader that fills the instruction memory before the core
// is allowed to run. The incoming stream is length-prefixed and checksummed:
//
//   LEN_HI, LEN_LO        : word count N (big-endian, 16 bits)
//   4N payload bytes      : big-endian 32-bit words, MSB first
//   CSUM                  : XOR of all 4N payload bytes (0x00 when N == 0)
//
// Each assembled word is written to consecutive word addresses starting at 0.
// The core is held in reset until the whole image has arrived and its checksum
// matches. A bad length or checksum parks the loader in a sticky error state.
//
// Parameters:
//   MAX_WORDS   largest accepted image in words (<= instruction memory depth)
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    source presents a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   wr_en       instruction-memory write strobe, one cycle per word
//   wr_addr     word index (not a byte address), zero-extended word counter
//   wr_data     assembled word
//   core_reset  active-high hold for the core, released once load succeeds
//   done        image loaded and checksum matched (sticky)
//   error       length out of range or checksum mismatch (sticky)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // One bit wider than the length field so the bound compare never truncates.
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wordCnt_q, wordCnt_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  xor_q, xor_d;
  logic        wrEn_q, wrEn_d;
  logic [31:0] wrData_q, wrData_d;

  logic        xfer;
  logic [15:0] newLen;

  // The loader only refuses bytes once it has reached a terminal state, so it
  // never stalls a source in the middle of an image.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA)   || (state_q == S_CSUM);
  end

  assign xfer   = in_valid && in_ready;
  assign newLen = {len_q[15:8], in_data};

  // Next-state and datapath update. The assembly register keeps only the three
  // leading bytes of a word; the fourth byte is merged directly into wr_data.
  // The word counter advances during the write cycle itself, so wr_addr still
  // shows the address of the word being written while wr_en is high.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    asm_d     = asm_q;
    xor_d     = xor_q;
    wrEn_d    = 1'b0;
    wrData_d  = wrData_q;

    if (wrEn_q) begin
      wordCnt_d = wordCnt_q + 16'd1;
    end

    case (state_q)
      S_LEN_HI: begin
        xor_d = 8'h00;
        if (xfer) begin
          len_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_d = newLen;
          if ({1'b0, newLen} > MaxWords) begin
            state_d = S_ERR;
          end else if (newLen == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          xor_d     = xor_q ^ in_data;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            wrData_d = {asm_q, in_data};
            wrEn_d   = 1'b1;
            // The previous word's counter increment has always landed by now,
            // because at least three bytes separate two fourth-byte transfers.
            if (wordCnt_q + 16'd1 == len_q) begin
              state_d = S_CSUM;
            end
          end else begin
            asm_d = {asm_q[15:0], in_data};
          end
        end
      end

      S_CSUM: begin
        if (xfer) begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
      end

      default: begin
      end
    endcase
  end

  // State register. Reset abandons any partial image; words already written
  // to memory are simply left where they are.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_LEN_HI;
      len_q     <= 16'h0000;
      wordCnt_q <= 16'h0000;
      byteCnt_q <= 2'd0;
      asm_q     <= 24'h000000;
      xor_q     <= 8'h00;
      wrEn_q    <= 1'b0;
      wrData_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      asm_q     <= asm_d;
      xor_q     <= xor_d;
      wrEn_q    <= wrEn_d;
      wrData_q  <= wrData_d;
    end
  end

  // Terminal outputs decode the registered state, so done, error and the
  // release of core_reset all appear the cycle after the deciding byte.
  assign wr_en      = wrEn_q;
  assign wr_addr    = {16'h0000, wordCnt_q};
  assign wr_data    = wrData_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_reset = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A behavioural model parses each byte
// stream (length, big-endian words, XOR checksum) and predicts the write list
// and the final done/error outcome; a monitor collects the writes the DUT
// actually performs and each scenario task compares the two.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MaxWords = 64;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_reset;
  logic        done;
  logic        error;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0]  stream[$];
  logic [63:0] expWr[$];
  logic [63:0] obsWr[$];
  logic        expDone;
  logic        expErr;

  imem_loader #(.MAX_WORDS(MaxWords)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write the DUT performs, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && wr_en) obsWr.push_back({wr_addr, wr_data});
  end

  // Reference model: read the stream as the format describes it and list the
  // writes it implies plus the final verdict.
  function automatic void buildModel();
    int          n;
    logic [7:0]  x;
    logic [31:0] word;
    expWr.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    n = int'(stream[0]) * 256 + int'(stream[1]);
    if (n > MaxWords) begin
      expErr = 1'b1;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      word = {stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]};
      x = x ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
      expWr.push_back({32'(w), word});
    end
    expDone = (stream[2+4*n] == x);
    expErr  = !expDone;
  endfunction

  // Drive the whole stream, optionally with 1..maxGap idle cycles (carrying
  // garbage data) before each byte. Called and returns at posedge + 1.
  task automatic applyStimulus(input int maxGap);
    int gap;
    for (int i = 0; i < stream.size(); i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 1)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    obsWr.delete();
  endtask

  task automatic loadNominal(input logic [7:0] csum);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h20, 8'h09, 8'h00, 8'h0A, csum};
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({in_ready, wr_en, core_reset, done, error} !== 5'b10100) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got ready/wr_en/core_reset/done/error=%b want 10100",
               {in_ready, wr_en, core_reset, done, error});
    end
    nChecks++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_addr_data: got %h/%h want 0/0", wr_addr, wr_data);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Nominal image at one byte per cycle, checking wr_en cycle by cycle.
  task automatic test_nominal();
    logic        expW;
    logic [31:0] eAddr, eData;
    doReset();
    loadNominal(8'h0E);
    for (int i = 0; i < stream.size(); i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      @(posedge clk); #1;
      expW  = (i == 5) || (i == 9);
      eAddr = (i == 9) ? 32'd1 : 32'd0;
      eData = (i == 9) ? 32'h2009_000A : 32'h2008_0005;
      nChecks++;
      if (wr_en !== expW) begin
        nFails++;
        $display("[TB] FAIL nominal_wr_en[%0d]: got %b want %b", i, wr_en, expW);
      end
      if (expW) begin
        nChecks++;
        if (wr_addr !== eAddr || wr_data !== eData) begin
          nFails++;
          $display("[TB] FAIL nominal_word[%0d]: got %h/%h want %h/%h",
                   i, wr_addr, wr_data, eAddr, eData);
        end
      end
    end
    nChecks++;
    if ({done, core_reset, error, in_ready} !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL nominal_final: got done/core_reset/error/ready=%b want 1000",
               {done, core_reset, error, in_ready});
    end
    // Extra bytes after completion must be ignored.
    in_data = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    nChecks++;
    if (obsWr.size() != 2 || done !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL nominal_after_done: got writes=%0d done=%b want 2/1",
               obsWr.size(), done);
    end
  endtask

  task automatic test_bad_csum();
    doReset();
    loadNominal(8'h0F);
    applyStimulus(0);
    buildModel();
    nChecks++;
    if (obsWr.size() != expWr.size()) begin
      nFails++;
      $display("[TB] FAIL badcsum_count: got %0d want %0d", obsWr.size(), expWr.size());
    end else begin
      for (int i = 0; i < expWr.size(); i++) begin
        nChecks++;
        if (obsWr[i] !== expWr[i]) begin
          nFails++;
          $display("[TB] FAIL badcsum_write[%0d]: got %h want %h", i, obsWr[i], expWr[i]);
        end
      end
    end
    nChecks++;
    if ({error, core_reset, done} !== {expErr, 1'b1, expDone}) begin
      nFails++;
      $display("[TB] FAIL badcsum_final: got error/core_reset/done=%b want %b",
               {error, core_reset, done}, {expErr, 1'b1, expDone});
    end
  endtask

  task automatic test_empty();
    doReset();
    stream = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0);
    @(posedge clk); #1;
    nChecks++;
    if (obsWr.size() != 0) begin
      nFails++;
      $display("[TB] FAIL empty_writes: got %0d want 0", obsWr.size());
    end
    nChecks++;
    if ({done, core_reset, error} !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL empty_final: got done/core_reset/error=%b want 100",
               {done, core_reset, error});
    end
  endtask

  task automatic test_oversize();
    doReset();
    stream = '{8'h00, 8'h41};
    applyStimulus(0);
    nChecks++;
    if ({error, in_ready, done, core_reset} !== 4'b1001) begin
      nFails++;
      $display("[TB] FAIL oversize_next_cycle: got error/ready/done/core_reset=%b want 1001",
               {error, in_ready, done, core_reset});
    end
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(0);
    @(posedge clk); #1;
    nChecks++;
    if (obsWr.size() != 0 || error !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL oversize_sticky: got writes=%0d error=%b want 0/1",
               obsWr.size(), error);
    end
  endtask

  task automatic test_gapped();
    doReset();
    loadNominal(8'h0E);
    applyStimulus(3);
    buildModel();
    nChecks++;
    if (obsWr.size() != expWr.size()) begin
      nFails++;
      $display("[TB] FAIL gapped_count: got %0d want %0d", obsWr.size(), expWr.size());
    end else begin
      for (int i = 0; i < expWr.size(); i++) begin
        nChecks++;
        if (obsWr[i] !== expWr[i]) begin
          nFails++;
          $display("[TB] FAIL gapped_write[%0d]: got %h want %h", i, obsWr[i], expWr[i]);
        end
      end
    end
    nChecks++;
    if ({done, core_reset, error} !== {expDone, ~expDone, expErr}) begin
      nFails++;
      $display("[TB] FAIL gapped_final: got done/core_reset/error=%b want %b",
               {done, core_reset, error}, {expDone, ~expDone, expErr});
    end
  endtask

  task automatic test_reset_mid_load();
    doReset();
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    applyStimulus(0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    nChecks++;
    if ({core_reset, wr_en} !== 2'b10 || wr_addr !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL midreset_hold: got core_reset/wr_en=%b addr=%h want 10/0",
               {core_reset, wr_en}, wr_addr);
    end
    nChecks++;
    if (obsWr.size() != 1 || (obsWr.size() == 1 && obsWr[0] !== {32'd0, 32'h2008_0005})) begin
      nFails++;
      $display("[TB] FAIL midreset_first_pass: got %0d writes (first %h) want 1 (%h)",
               obsWr.size(), (obsWr.size() > 0) ? obsWr[0] : 64'h0,
               {32'd0, 32'h2008_0005});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    obsWr.delete();
    loadNominal(8'h0E);
    applyStimulus(0);
    buildModel();
    nChecks++;
    if (obsWr.size() != expWr.size()) begin
      nFails++;
      $display("[TB] FAIL midreset_replay_count: got %0d want %0d", obsWr.size(), expWr.size());
    end else begin
      for (int i = 0; i < expWr.size(); i++) begin
        nChecks++;
        if (obsWr[i] !== expWr[i]) begin
          nFails++;
          $display("[TB] FAIL midreset_replay[%0d]: got %h want %h", i, obsWr[i], expWr[i]);
        end
      end
    end
    nChecks++;
    if (done !== 1'b1 || core_reset !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_replay_done: got done/core_reset=%b%b want 10",
               done, core_reset);
    end
  endtask

  // Random images, including the MAX_WORDS and MAX_WORDS+1 boundaries,
  // random checksum corruption and random source gaps.
  task automatic test_random(input int iters);
    logic [15:0] n;
    logic [7:0]  x, b;
    for (int it = 0; it < iters; it++) begin
      if (it == 0)                 n = 16'(MaxWords);
      else if (it == 1)            n = 16'(MaxWords + 1);
      else if ($urandom % 5 == 0)  n = 16'($urandom_range(65535, MaxWords + 1));
      else                         n = 16'($urandom_range(6, 0));
      stream.delete();
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
      x = 8'h00;
      if (int'(n) <= MaxWords) begin
        for (int k = 0; k < 4 * int'(n); k++) begin
          b = 8'($urandom);
          x = x ^ b;
          stream.push_back(b);
        end
        if ($urandom % 3 == 0) x = x ^ 8'($urandom_range(255, 1));
        stream.push_back(x);
      end else begin
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
      end
      doReset();
      applyStimulus(int'($urandom_range(2, 0)));
      @(posedge clk); #1;
      buildModel();
      nChecks++;
      if (obsWr.size() != expWr.size()) begin
        nFails++;
        $display("[TB] FAIL random%0d_count: got %0d want %0d (N=%0d)",
                 it, obsWr.size(), expWr.size(), n);
      end else begin
        for (int i = 0; i < expWr.size(); i++) begin
          nChecks++;
          if (obsWr[i] !== expWr[i]) begin
            nFails++;
            $display("[TB] FAIL random%0d_write[%0d]: got %h want %h",
                     it, i, obsWr[i], expWr[i]);
          end
        end
      end
      nChecks++;
      if ({done, error, core_reset, in_ready} !== {expDone, expErr, ~expDone, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL random%0d_final: got done/error/core_reset/ready=%b want %b",
                 it, {done, error, core_reset, in_ready},
                 {expDone, expErr, ~expDone, 1'b0});
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_bad_csum();
    test_empty();
    test_oversize();
    test_gapped();
    test_reset_mid_load();
    test_random(20);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
